// File: rtl/verinject_pkg.sv
`default_nettype none
// ============================================================================
// verinject_pkg : shared injector-state codes and sequencer state encoding
// Rev 1.0
// ============================================================================
package verinject_pkg;

  localparam logic [31:0] VERINJECT_STATE_NONE       = 32'hFFFF_FFFF;
  localparam logic [31:0] VERINJECT_STATE_RESET_FIFO = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_CLEAR = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/verinject_schedule_table.sv
`default_nettype none
// ============================================================================
// verinject_schedule_table : DEPTH x {cycle,index} store, async read port
// Rev 1.0
// ============================================================================
module verinject_schedule_table #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_cycle,
  input  logic [31:0]           wr_index,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_cycle,
  output logic [31:0]           rd_index,
  output logic [31:0]           last_cycle
);

  logic [63:0] r_mem [DEPTH];
  logic [31:0] r_last_cycle;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= {wr_cycle, wr_index};
    end
  end

  // Most recently stored cycle, used by the caller's non-decreasing check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_cycle <= 32'd0;
    end else if (wr_en) begin
      r_last_cycle <= wr_cycle;
    end
  end

  assign rd_cycle   = r_mem[rd_addr][63:32];
  assign rd_index   = r_mem[rd_addr][31:0];
  assign last_cycle = r_last_cycle;

endmodule
`default_nettype wire

// File: rtl/verinject_fault_sequencer.sv
`default_nettype none
// ============================================================================
// verinject_fault_sequencer : replays a (cycle,index) schedule onto the
// verinject__injector_state broadcast. Rev 1.0
// ============================================================================
module verinject_fault_sequencer
  import verinject_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_cycle,
  input  logic [31:0]           load_index,
  output logic                  load_error,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   entry_count,
  output logic [DEPTH_LOG2:0]   injected_count,
  output logic [15:0]           slip_count,
  output logic [31:0]           cycle_count,
  output logic [31:0]           verinject__injector_state
);

  localparam logic [DEPTH_LOG2:0] C_DEPTH   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_PTR_ONE = (DEPTH_LOG2+1)'(1);

  seq_state_e          r_state, w_state_next;
  logic [DEPTH_LOG2:0] r_entry_count, r_rd_ptr, r_injected_count;
  logic [15:0]         r_slip_count;
  logic [31:0]         r_cycle_count, r_inj_state;
  logic                r_load_error;

  logic                w_idle_like, w_flush, w_load_xfer, w_load_bad, w_wr_en;
  logic [31:0]         w_last_cycle, w_rd_cycle, w_rd_index;
  logic [31:0]         w_k_next, w_inj_next;
  logic [DEPTH_LOG2:0] w_ptr_cand;
  logic                w_emit, w_slip;

  assign w_idle_like = (r_state == SEQ_IDLE) || (r_state == SEQ_DONE);
  assign load_ready  = w_idle_like && (r_entry_count < C_DEPTH);
  assign w_flush     = flush && w_idle_like;
  assign w_load_xfer = load_valid && load_ready;
  assign w_load_bad  = (load_index >= VERINJECT_STATE_RESET_FIFO) ||
                       ((r_entry_count != '0) && (load_cycle < w_last_cycle));
  assign w_wr_en     = w_load_xfer && !w_flush && !w_load_bad;

  verinject_schedule_table #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_table (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (w_wr_en),
    .wr_addr    (r_entry_count[DEPTH_LOG2-1:0]),
    .wr_cycle   (load_cycle),
    .wr_index   (load_index),
    .rd_addr    (w_ptr_cand[DEPTH_LOG2-1:0]),
    .rd_cycle   (w_rd_cycle),
    .rd_index   (w_rd_index),
    .last_cycle (w_last_cycle)
  );

  // Next-state lookahead: decide what the broadcast shows in the coming cycle.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_cycle_count;
    w_ptr_cand   = r_rd_ptr;
    case (r_state)
      SEQ_IDLE, SEQ_DONE: begin
        if (start) w_state_next = SEQ_CLEAR;
      end
      SEQ_CLEAR: begin
        w_k_next   = 32'd0;
        w_ptr_cand = '0;
        if (abort)                     w_state_next = SEQ_IDLE;
        else if (r_entry_count == '0)  w_state_next = SEQ_DONE;
        else                           w_state_next = SEQ_RUN;
      end
      SEQ_RUN: begin
        w_k_next = sat_inc32(r_cycle_count);
        if (abort)                             w_state_next = SEQ_IDLE;
        else if (r_rd_ptr == r_entry_count)    w_state_next = SEQ_DONE;
      end
      default: w_state_next = SEQ_IDLE;
    endcase
  end

  assign w_emit = (w_state_next == SEQ_RUN) && (w_ptr_cand < r_entry_count) &&
                  (w_rd_cycle <= w_k_next);
  assign w_slip = w_emit && (w_rd_cycle < w_k_next);

  always_comb begin
    w_inj_next = VERINJECT_STATE_NONE;
    if (w_state_next == SEQ_CLEAR)  w_inj_next = VERINJECT_STATE_RESET_FIFO;
    else if (w_emit)                w_inj_next = w_rd_index;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= SEQ_IDLE;
      r_inj_state      <= VERINJECT_STATE_NONE;
      r_load_error     <= 1'b0;
      r_entry_count    <= '0;
      r_rd_ptr         <= '0;
      r_injected_count <= '0;
      r_slip_count     <= 16'd0;
      r_cycle_count    <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_inj_state  <= w_inj_next;
      r_load_error <= w_load_xfer && !w_flush && w_load_bad;

      if (w_flush)       r_entry_count <= '0;
      else if (w_wr_en)  r_entry_count <= r_entry_count + C_PTR_ONE;

      if (w_state_next == SEQ_CLEAR) begin
        r_rd_ptr         <= '0;
        r_injected_count <= '0;
        r_slip_count     <= 16'd0;
        r_cycle_count    <= 32'd0;
      end else if (w_state_next == SEQ_RUN) begin
        r_cycle_count <= w_k_next;
        if (w_emit) begin
          r_rd_ptr         <= w_ptr_cand + C_PTR_ONE;
          r_injected_count <= r_injected_count + C_PTR_ONE;
          if (w_slip && (r_slip_count != 16'hFFFF)) begin
            r_slip_count <= r_slip_count + 16'd1;
          end
        end
      end
    end
  end

  assign busy                      = (r_state == SEQ_CLEAR) || (r_state == SEQ_RUN);
  assign done                      = (r_state == SEQ_DONE);
  assign load_error                = r_load_error;
  assign entry_count               = r_entry_count;
  assign injected_count            = r_injected_count;
  assign slip_count                = r_slip_count;
  assign cycle_count               = r_cycle_count;
  assign verinject__injector_state = r_inj_state;

endmodule
`default_nettype wire
